// File: rtl/ramio_pkg.sv
// ramio_pkg: ramio transfer-type encodings and arbiter state type
package ramio_pkg;
  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_BU   = 3'b001;
  localparam logic [2:0] RD_HU   = 3'b010;
  localparam logic [2:0] RD_W    = 3'b011;
  localparam logic [2:0] RD_B    = 3'b101;
  localparam logic [2:0] RD_H    = 3'b110;
  localparam logic [2:0] RD_WS   = 3'b111;
  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_B    = 2'b01;
  localparam logic [1:0] WR_H    = 2'b10;
  localparam logic [1:0] WR_W    = 2'b11;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
endpackage

// File: rtl/ramio_arbiter.sv
// ramio_arbiter: round-robin, enable-locked sharing of one ramio port between two masters
module ramio_arbiter
  import ramio_pkg::*;
#(
  parameter int TimeoutCycles = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_enable,
  input  logic [2:0]  m0_read_type,
  input  logic [1:0]  m0_write_type,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_data_in,
  output logic [31:0] m0_data_out,
  output logic        m0_data_out_ready,
  output logic        m0_busy,
  input  logic        m1_enable,
  input  logic [2:0]  m1_read_type,
  input  logic [1:0]  m1_write_type,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_data_in,
  output logic [31:0] m1_data_out,
  output logic        m1_data_out_ready,
  output logic        m1_busy,
  output logic        ramio_enable,
  output logic [2:0]  ramio_read_type,
  output logic [1:0]  ramio_write_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic [31:0] ramio_data_out,
  input  logic        ramio_data_out_ready,
  input  logic        ramio_busy,
  output logic [1:0]  grant,
  output logic        error
);
  localparam logic [31:0] Limit = 32'(TimeoutCycles);
  arb_state_t state, next_state;
  logic ptr;
  logic [31:0] cnt;
  // ptr=1 favours m1; the counter restarts on every fresh grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != IDLE && next_state != state) ptr <= next_state == OWN0;
      cnt <= (next_state == state && state != IDLE) ? (cnt < Limit ? cnt + 32'd1 : cnt) : '0;
      if (state != IDLE && cnt + 32'd1 >= Limit) error <= 1'b1;
    end
  end
  // on release the other master wins over everything
  always_comb begin
    next_state = IDLE;
    unique case (state)
      IDLE:    next_state = (m0_enable && m1_enable) ? (ptr ? OWN1 : OWN0) :
                            m0_enable ? OWN0 : m1_enable ? OWN1 : IDLE;
      OWN0:    next_state = m0_enable ? OWN0 : m1_enable ? OWN1 : IDLE;
      OWN1:    next_state = m1_enable ? OWN1 : m0_enable ? OWN0 : IDLE;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    grant             = state == OWN0 ? 2'b01 : state == OWN1 ? 2'b10 : 2'b00;
    ramio_enable      = grant[0] ? m0_enable     : grant[1] ? m1_enable     : 1'b0;
    ramio_read_type   = grant[0] ? m0_read_type  : grant[1] ? m1_read_type  : RD_NONE;
    ramio_write_type  = grant[0] ? m0_write_type : grant[1] ? m1_write_type : WR_NONE;
    ramio_address     = grant[0] ? m0_address    : grant[1] ? m1_address    : '0;
    ramio_data_in     = grant[0] ? m0_data_in    : grant[1] ? m1_data_in    : '0;
    m0_data_out       = ramio_data_out;
    m1_data_out       = ramio_data_out;
    m0_data_out_ready = grant[0] & ramio_data_out_ready;
    m1_data_out_ready = grant[1] & ramio_data_out_ready;
    m0_busy           = grant[0] ? ramio_busy : 1'b1;
    m1_busy           = grant[1] ? ramio_busy : 1'b1;
  end
endmodule
